// File: rtl/lector_destinos_pkg.sv
// ============================================================================
// Module   : lector_destinos_pkg
// Brief    : Shared state encodings, source identifiers and default word width
//            for the destination-FIFO drain logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lector_destinos_pkg;

    localparam int c_BW_DEFAULT = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic SRC_D0 = 1'b0;
    localparam logic SRC_D1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/lector_destinos_rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-request round-robin arbiter; the pointer remembers the last
//            source served so that a tie goes to the other one.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import lector_destinos_pkg::*;
(
    input  logic       clk,
    input  logic       reset_L,
    input  logic       clr,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic r_last;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (r_last == SRC_D1) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_last <= SRC_D1;
        end else if (clr) begin
            r_last <= SRC_D1;
        end else if (|grant) begin
            r_last <= grant[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/lector_destinos.sv
// ============================================================================
// Module   : lector_destinos
// Brief    : Pops destination FIFOs D0/D1 round-robin, merges them onto one
//            stream, counts words per source and checks the destination bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lector_destinos
    import lector_destinos_pkg::*;
#(
    parameter int BW       = c_BW_DEFAULT,
    parameter int DEST_BIT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             init,
    input  logic             pause,
    input  logic             D0_empty,
    input  logic             D0_error_output,
    input  logic [BW-1:0]    D0_data_out,
    output logic             D0_rd,
    input  logic             D1_empty,
    input  logic             D1_error_output,
    input  logic [BW-1:0]    D1_data_out,
    output logic             D1_rd,
    output logic             out_valid,
    output logic [BW-1:0]    out_data,
    output logic             out_src,
    output logic [CNT_W-1:0] cnt_D0,
    output logic [CNT_W-1:0] cnt_D1,
    output logic             mismatch_err,
    output logic             error_out,
    output logic             idle_out
);

    state_t            r_state;
    logic              r_idle;
    logic              r_error;
    logic              r_pend;
    logic              r_pend_src;
    logic              r_valid;
    logic [BW-1:0]     r_data;
    logic              r_src;
    logic [CNT_W-1:0]  r_cnt_d0;
    logic [CNT_W-1:0]  r_cnt_d1;
    logic              r_mismatch;

    logic              w_any_err;
    logic              w_frozen;
    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic [BW-1:0]     w_word;

    assign w_any_err = D0_error_output | D1_error_output;
    // Any error flag blocks both FIFOs at once, not just the one that raised it.
    assign w_frozen  = ~reset_L | init | pause | w_any_err | (r_state == ST_ERROR);
    assign w_req     = {~D1_empty & ~w_frozen, ~D0_empty & ~w_frozen};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_L (reset_L),
        .clr     (init),
        .req     (w_req),
        .grant   (w_grant)
    );

    assign D0_rd = w_grant[0];
    assign D1_rd = w_grant[1];

    // FIFO read data appears the cycle after the pop; remember who was popped.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_pend     <= 1'b0;
            r_pend_src <= SRC_D0;
        end else begin
            r_pend     <= |w_grant;
            r_pend_src <= w_grant[1];
        end
    end

    assign w_word = (r_pend_src == SRC_D1) ? D1_data_out : D0_data_out;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_src      <= SRC_D0;
            r_cnt_d0   <= '0;
            r_cnt_d1   <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_valid <= r_pend;
            if (r_pend) begin
                r_data <= w_word;
                r_src  <= r_pend_src;
            end
            if (init) begin
                r_cnt_d0   <= '0;
                r_cnt_d1   <= '0;
                r_mismatch <= 1'b0;
            end else if (r_pend) begin
                if (r_pend_src == SRC_D1) begin
                    r_cnt_d1 <= r_cnt_d1 + CNT_W'(1);
                end else begin
                    r_cnt_d0 <= r_cnt_d0 + CNT_W'(1);
                end
                if (w_word[DEST_BIT] != r_pend_src) begin
                    r_mismatch <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= ST_IDLE;
            r_idle  <= 1'b1;
            r_error <= 1'b0;
        end else if (init) begin
            r_state <= ST_IDLE;
            r_idle  <= 1'b1;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_err) begin
                        r_state <= ST_ERROR;
                        r_idle  <= 1'b0;
                        r_error <= 1'b1;
                    end else if (~D0_empty | ~D1_empty) begin
                        r_state <= ST_READ;
                        r_idle  <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (w_any_err) begin
                        r_state <= ST_ERROR;
                        r_error <= 1'b1;
                    end else if (D0_empty & D1_empty & ~r_pend) begin
                        r_state <= ST_IDLE;
                        r_idle  <= 1'b1;
                    end
                end
                ST_ERROR: begin
                    r_state <= ST_ERROR;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idle  <= 1'b1;
                    r_error <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid    = r_valid;
    assign out_data     = r_data;
    assign out_src      = r_src;
    assign cnt_D0       = r_cnt_d0;
    assign cnt_D1       = r_cnt_d1;
    assign mismatch_err = r_mismatch;
    assign error_out    = r_error;
    assign idle_out     = r_idle;

endmodule

`default_nettype wire
